// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared encodings for the LED pattern generator and its helpers.
//   mode_t : animation mode as it appears on the 2-bit mode switches
//   dir_t  : travel direction of the one-hot dot in BOUNCE mode
// ---------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_ROTATE = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous board inputs (switches, buttons).
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input bus (WIDTH bits, each bit synchronised alone)
//   q   : synchronised output, two clk edges behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: flops are written with <= so both stages sample their inputs
   // from before the edge; a blocking '=' here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Animated LED driver: STATIC, BLINK, ROTATE or BOUNCE, stepping at TICK_HZ.
//   clk      : system clock (CLK_HZ), rising edge
//   rst      : asynchronous active-high reset
//   mode_sw  : mode select straight from slide switches (asynchronous)
//   hold     : freezes prescaler and animation while high
//   flag_led : registered LED drive, LED_W bits
//   tick_o   : registered one-cycle pulse, high while a new step is shown
// ---------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int               LED_W   = 16,
   parameter int               CLK_HZ  = 100_000_000,
   parameter int               TICK_HZ = 4,
   parameter logic [LED_W-1:0] PATTERN = 16'hAE20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_sw,
   input  logic             hold,
   output logic [LED_W-1:0] flag_led,
   output logic             tick_o
);

   localparam int             TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int             CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [LED_W-1:0] DOT_LSB = LED_W'(1);

   logic [1:0]       mode_s_raw;
   mode_t            mode_s;
   mode_t            mode_q;
   dir_t             dir;
   logic             phase;
   logic             phase_next;
   logic [CNT_W-1:0] cnt;
   logic             tick_int;
   logic             mode_chg;

   sync_2ff #(.WIDTH(2)) u_mode_sync (
      .clk (clk),
      .rst (rst),
      .d   (mode_sw),
      .q   (mode_s_raw)
   );

   assign mode_s     = mode_t'(mode_s_raw);
   assign mode_chg   = (mode_s != mode_q);
   assign tick_int   = (cnt == CNT_MAX) && !hold;
   assign phase_next = ~phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= MODE_STATIC;
         cnt      <= '0;
         dir      <= DIR_LEFT;
         phase    <= 1'b0;
         flag_led <= PATTERN;
         tick_o   <= 1'b0;
      end else if (mode_chg) begin
         // A mode switch restarts the animation and swallows any tick that
         // lands on the same edge, so the new mode always begins cleanly.
         mode_q   <= mode_s;
         cnt      <= '0;
         dir      <= DIR_LEFT;
         phase    <= 1'b0;
         flag_led <= (mode_s == MODE_BOUNCE) ? DOT_LSB : PATTERN;
         tick_o   <= 1'b0;
      end else begin
         tick_o <= tick_int;
         if (!hold) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         end
         if (tick_int) begin
            case (mode_q)
               MODE_STATIC: flag_led <= PATTERN;
               MODE_BLINK: begin
                  phase    <= phase_next;
                  flag_led <= phase_next ? '0 : PATTERN;
               end
               MODE_ROTATE: flag_led <= {flag_led[LED_W-2:0], flag_led[LED_W-1]};
               MODE_BOUNCE: begin
                  // Turn around on the step that would fall off the end, so
                  // the end LEDs are lit for one step only.
                  if (dir == DIR_LEFT) begin
                     if (flag_led[LED_W-1]) begin
                        dir      <= DIR_RIGHT;
                        flag_led <= flag_led >> 1;
                     end else begin
                        flag_led <= flag_led << 1;
                     end
                  end else begin
                     if (flag_led[0]) begin
                        dir      <= DIR_LEFT;
                        flag_led <= flag_led << 1;
                     end else begin
                        flag_led <= flag_led >> 1;
                     end
                  end
               end
               default: flag_led <= flag_led;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen with TICK_DIV = 8. Expected LED
// values are pushed into a queue ahead of time; a negedge monitor pops one
// entry per tick_o pulse and compares it with flag_led.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

   localparam int          LED_W   = 16;
   localparam logic [15:0] PAT     = 16'hAE20;
   localparam int          DIV     = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode_sw;
   logic        hold;
   logic [15:0] flag_led;
   logic        tick_o;

   int checks   = 0;
   int failures = 0;

   logic [15:0] sb_q[$];
   logic        sb_en = 1'b0;

   led_pattern_gen #(
      .LED_W   (LED_W),
      .CLK_HZ  (8),
      .TICK_HZ (1),
      .PATTERN (PAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_sw  (mode_sw),
      .hold     (hold),
      .flag_led (flag_led),
      .tick_o   (tick_o)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: one expected value consumed per animation step.
   always @(negedge clk) begin
      if (sb_en && tick_o) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra_tick: got tick with flag_led=%h, expected no tick", flag_led);
         end else begin
            logic [15:0] exp_v;
            exp_v = sb_q.pop_front();
            if (flag_led !== exp_v) begin
               failures++;
               $display("FAIL sb_step: flag_led=%h expected=%h", flag_led, exp_v);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
      return r;
   endfunction

   // Drive a new mode and return at the negedge right after it is applied
   // (two sync edges plus the update edge).
   task automatic enter_mode(input logic [1:0] m);
      @(negedge clk);
      mode_sw = m;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; mode_sw = 2'd0; hold = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (flag_led !== PAT || tick_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_init: flag_led=%h tick_o=%b expected %h/0", flag_led, tick_o, PAT);
      end
      rst = 1'b0;
      enter_mode(2'd2);
      repeat (10) begin @(posedge clk); @(negedge clk); end
      checks++;
      if (flag_led !== 16'h5C41) begin
         failures++;
         $display("FAIL reset_prerun: flag_led=%h expected 5c41", flag_led);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (flag_led !== PAT || tick_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: flag_led=%h tick_o=%b expected %h/0", flag_led, tick_o, PAT);
      end
      mode_sw = 2'd0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (tick_o !== (n % DIV == 0) || flag_led !== PAT) begin
            failures++;
            $display("FAIL static_run cycle %0d: tick_o=%b flag_led=%h expected %b/%h",
                     n, tick_o, flag_led, (n % DIV == 0), PAT);
         end
      end
   endtask

   task automatic test_blink;
      int gap;
      enter_mode(2'd1);
      checks++;
      if (flag_led !== PAT || tick_o !== 1'b0) begin
         failures++;
         $display("FAIL blink_entry: flag_led=%h tick_o=%b expected %h/0", flag_led, tick_o, PAT);
      end
      sb_q = {};
      for (int i = 0; i < 4; i++) sb_q.push_back((i % 2 == 0) ? 16'h0000 : PAT);
      sb_en = 1'b1;
      gap = 0;
      for (int c = 0; c < 4 * DIV + 10 && sb_q.size() != 0; c++) begin
         @(posedge clk); @(negedge clk);
         gap++;
         if (tick_o) begin
            checks++;
            if (gap !== DIV) begin
               failures++;
               $display("FAIL blink_gap: %0d cycles expected %0d", gap, DIV);
            end
            gap = 0;
         end
      end
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL blink_timeout: %0d steps missing, expected 0", sb_q.size());
      end
   endtask

   task automatic test_rotate;
      enter_mode(2'd2);
      checks++;
      if (flag_led !== PAT) begin
         failures++;
         $display("FAIL rotate_entry: flag_led=%h expected %h", flag_led, PAT);
      end
      sb_q = {};
      for (int i = 1; i <= 16; i++) sb_q.push_back(rotl(PAT, i));
      sb_en = 1'b1;
      for (int c = 0; c < 16 * DIV + 10 && sb_q.size() != 0; c++) @(negedge clk);
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL rotate_timeout: %0d steps missing, expected 0", sb_q.size());
      end
   endtask

   task automatic test_bounce;
      enter_mode(2'd3);
      checks++;
      if (flag_led !== 16'h0001) begin
         failures++;
         $display("FAIL bounce_entry: flag_led=%h expected 0001", flag_led);
      end
      sb_q = {};
      for (int t = 1; t <= 31; t++) begin
         if (t <= 15)      sb_q.push_back(16'h1 << t);
         else if (t <= 30) sb_q.push_back(16'h1 << (30 - t));
         else              sb_q.push_back(16'h1 << (t - 30));
      end
      sb_en = 1'b1;
      for (int c = 0; c < 31 * DIV + 10 && sb_q.size() != 0; c++) @(negedge clk);
      sb_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL bounce_timeout: %0d steps missing, expected 0", sb_q.size());
      end
   endtask

   task automatic test_hold;
      int n;
      enter_mode(2'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (tick_o !== 1'b0 || flag_led !== PAT) begin
            failures++;
            $display("FAIL hold_frozen cycle %0d: tick_o=%b flag_led=%h expected 0/%h",
                     i, tick_o, flag_led, PAT);
         end
      end
      hold = 1'b0;
      n = 0;
      while (n < 20) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (tick_o) break;
      end
      checks++;
      if (n !== 5 || flag_led !== 16'h5C41) begin
         failures++;
         $display("FAIL hold_resume: tick after %0d cycles flag_led=%h, expected 5 cycles 5c41",
                  n, flag_led);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      // Counter is 0 here; the switch goes in when it reaches 5, so the
      // mode update lands on the edge where the count is 7.
      repeat (5) @(posedge clk);
      @(negedge clk);
      mode_sw = 2'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tick_o !== 1'b0 || flag_led !== 16'h0001) begin
         failures++;
         $display("FAIL modechg_collide: tick_o=%b flag_led=%h expected 0/0001", tick_o, flag_led);
      end
      n = 0;
      while (n < 20) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (tick_o) break;
      end
      checks++;
      if (n !== DIV || flag_led !== 16'h0002) begin
         failures++;
         $display("FAIL modechg_next: tick after %0d cycles flag_led=%h, expected %0d cycles 0002",
                  n, flag_led, DIV);
      end
   endtask

   initial begin
      test_reset;
      test_blink;
      test_rotate;
      test_bounce;
      test_hold;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
